mem_stage_access: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns MemRead/MemWrite into a valid/ready request and response transaction on the data-memory bus, and stalls the pipeline until the response arrives.
- Registers the MEM/WB stage outputs and computes the branch-taken select.
- Sits between the EX/MEM register and the MEM/WB consumers (writeback mux, register file).

---
 rtl/mem_stage_access_pkg.sv | 24 ++
 rtl/mem_stage_access_if.sv | 25 ++
 rtl/mem_timeout_counter.sv | 32 +++
 rtl/mem_stage_access.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared types for the MEM-stage data-memory access block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_access_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Everything the writeback mux and register file consume from MEM/WB.
  typedef struct packed {
    logic [XLEN-1:0]  readData;
    logic [XLEN-1:0]  aluResult;
    logic [REG_W-1:0] rd;
    logic             MemtoReg;
    logic             RegWrite;
    logic             valid;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory bus: valid/ready request channel plus a valid-only response channel.
// Latency: n/a (wires only).
// Backpressure: request held while mem_req_ready is low; responses cannot be stalled.
interface mem_stage_access_if;
  import mem_stage_access_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter: tc is high during the TERMINAL-th enabled cycle after a clear.
// Latency: tc is combinational from the count register.
// Backpressure: none; holds at the terminal count until cleared.
module mem_timeout_counter #(
  parameter int CNT_W    = 5,
  parameter int TERMINAL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(TERMINAL - 1));
  assign o_tc = w_tc;

  // Count enabled cycles, saturating at the terminal value so tc stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: issues loads/stores on the data bus, registers MEM/WB outputs, computes PCSrc.
// Latency: 1 cycle for non-memory ops; >= 2 cycles for memory ops (accept, then response).
// Backpressure: stall held high from request until the response (or timeout) cycle.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    PC_in,
  input  logic [XLEN-1:0]    aluResult_in,
  input  logic [XLEN-1:0]    data2_in,
  input  logic [REG_W-1:0]   rd_in,
  input  logic               Branch_in,
  input  logic               MemRead_in,
  input  logic               MemtoReg_in,
  input  logic               MemWrite_in,
  input  logic               RegWrite_in,
  input  logic               zero_in,
  mem_stage_access_if.master bus,
  output logic               stall,
  output logic               PCSrc_out,
  output logic [XLEN-1:0]    PC_target_out,
  output logic [XLEN-1:0]    readData_out,
  output logic [XLEN-1:0]    aluResult_out,
  output logic [REG_W-1:0]   rd_out,
  output logic               MemtoReg_out,
  output logic               RegWrite_out,
  output logic               wb_valid_out,
  output logic               err_out
);

  state_t          r_state;
  state_t          w_state_nxt;
  mem_wb_t         r_wb;
  logic            r_err;

  logic            w_mem_op;
  logic            w_illegal;
  logic            w_tc;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic            w_req_valid;
  logic            w_load;
  logic [XLEN-1:0] w_read_data;
  logic            w_regwrite;
  logic            w_err;

  // Exactly one of read/write is a real access; both together is malformed.
  assign w_mem_op  = MemRead_in ^ MemWrite_in;
  assign w_illegal = MemRead_in & MemWrite_in;

  // The counter only runs while a request is outstanding and restarts from 0 each time.
  assign w_cnt_clr = (r_state == IDLE);
  assign w_cnt_en  = (r_state == WAIT);

  mem_timeout_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Next state and the MEM/WB load decision; a response beats a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_load      = 1'b0;
    w_read_data = '0;
    w_regwrite  = RegWrite_in;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_req_valid = 1'b1;
          if (bus.mem_req_ready) begin
            w_state_nxt = WAIT;
          end
        end else begin
          w_load     = 1'b1;
          w_regwrite = RegWrite_in & ~w_illegal;
          w_err      = w_illegal;
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          w_load      = 1'b1;
          w_read_data = MemRead_in ? bus.mem_rsp_rdata : '0;
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          w_load      = 1'b1;
          w_regwrite  = 1'b0;
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MEM/WB register: load on completion, otherwise hold data and insert a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb  <= '0;
      r_err <= 1'b0;
    end else if (w_load) begin
      r_wb.readData  <= w_read_data;
      r_wb.aluResult <= aluResult_in;
      r_wb.rd        <= rd_in;
      r_wb.MemtoReg  <= MemtoReg_in;
      r_wb.RegWrite  <= w_regwrite;
      r_wb.valid     <= 1'b1;
      r_err          <= w_err;
    end else begin
      r_wb.valid     <= 1'b0;
      r_err          <= 1'b0;
    end
  end

  // Request fields come straight from EX/MEM, which is frozen by stall until acceptance.
  assign bus.mem_req_valid = w_req_valid & reset;
  assign bus.mem_req_we    = MemWrite_in;
  assign bus.mem_req_addr  = aluResult_in;
  assign bus.mem_req_wdata = data2_in;

  assign stall = w_mem_op & ~((r_state == WAIT) & (bus.mem_rsp_valid | w_tc));

  assign PCSrc_out     = Branch_in & zero_in;
  assign PC_target_out = PC_in;

  assign readData_out  = r_wb.readData;
  assign aluResult_out = r_wb.aluResult;
  assign rd_out        = r_wb.rd;
  assign MemtoReg_out  = r_wb.MemtoReg;
  assign RegWrite_out  = r_wb.RegWrite;
  assign wb_valid_out  = r_wb.valid;
  assign err_out       = r_err;

endmodule
